// File: rtl/branch_fetch_seq.sv
// rtl/branch_fetch_seq.sv - Moore control sequencer for instruction fetch and conditional branch
//
// Ports:
//   clock, clear            rising-edge clock, synchronous active-low reset
//   start, auto_run         begin one instruction from IDLE / loop DONE->T0
//   ir_opcode, con_ff       IR[31:27] and CON FF result from the datapath
//   incPC..imm_sel          one-bit datapath enables
//   BusDataSelect, ALU_op   bus source select and ALU operation
//   busy, done, illegal     status: not idle / branch completed / bad opcode
//   taken, instr_count      last branch loaded PC / retired branch count

module branch_fetch_seq #(
    parameter int         MEM_WAIT  = 1,
    parameter logic [4:0] BR_OPCODE = 5'b01001,
    parameter int         CNT_W     = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             auto_run,
    input  logic [4:0]       ir_opcode,
    input  logic             con_ff,
    output logic             incPC,
    output logic             e_PC,
    output logic             e_IR,
    output logic             e_Y,
    output logic             e_Z,
    output logic             e_MAR,
    output logic             e_MDR,
    output logic             MDR_read,
    output logic             ram_read,
    output logic             Gra,
    output logic             e_Rout,
    output logic             e_CON_FF,
    output logic             imm_sel,
    output logic [4:0]       BusDataSelect,
    output logic [3:0]       ALU_op,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             taken,
    output logic [CNT_W-1:0] instr_count
);

    generate
        if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
            $error("branch_fetch_seq: MEM_WAIT must be in 1..15");
        end
    endgenerate

    localparam logic [4:0] BUS_NONE = 5'b00000;
    localparam logic [4:0] BUS_PC   = 5'b10100;
    localparam logic [4:0] BUS_ZLO  = 5'b10011;
    localparam logic [4:0] BUS_MDR  = 5'b10101;
    localparam logic [4:0] BUS_C    = 5'b01100;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    // ILL exists so the illegal pulse is a pure state decode, one cycle after DECODE.
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T0W, S_T1, S_T1W, S_T1C, S_T2, S_DECODE,
        S_ILL, S_BR3, S_BR4, S_BR5, S_BR6, S_DONE
    } state_t;

    state_t     state, state_next;
    logic [3:0] wait_cnt;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            taken       <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == S_T1)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_T1W && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == S_BR6)
                taken <= con_ff;
            if (state == S_DONE)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next    = state;
        incPC         = 1'b0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_MAR         = 1'b0;
        e_MDR         = 1'b0;
        MDR_read      = 1'b0;
        ram_read      = 1'b0;
        Gra           = 1'b0;
        e_Rout        = 1'b0;
        e_CON_FF      = 1'b0;
        imm_sel       = 1'b0;
        BusDataSelect = BUS_NONE;
        ALU_op        = 4'b0000;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        illegal       = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = S_T0;
            S_T0: begin
                BusDataSelect = BUS_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
                state_next    = S_T0W;
            end
            S_T0W:    state_next = S_T1;
            S_T1: begin
                BusDataSelect = BUS_ZLO;
                ram_read      = 1'b1;
                state_next    = S_T1W;
            end
            S_T1W: begin
                ram_read = 1'b1;
                if (wait_cnt == 4'd0) state_next = S_T1C;
            end
            S_T1C: begin
                MDR_read   = 1'b1;
                e_MDR      = 1'b1;
                state_next = S_T2;
            end
            S_T2: begin
                BusDataSelect = BUS_MDR;
                e_IR          = 1'b1;
                state_next    = S_DECODE;
            end
            S_DECODE: state_next = (ir_opcode == BR_OPCODE) ? S_BR3 : S_ILL;
            S_ILL: begin
                illegal    = 1'b1;
                state_next = S_IDLE;
            end
            S_BR3: begin
                Gra        = 1'b1;
                e_Rout     = 1'b1;
                e_CON_FF   = 1'b1;
                state_next = S_BR4;
            end
            S_BR4: begin
                BusDataSelect = BUS_PC;
                e_Y           = 1'b1;
                state_next    = S_BR5;
            end
            S_BR5: begin
                BusDataSelect = BUS_C;
                imm_sel       = 1'b1;
                ALU_op        = ALU_ADD;
                e_Z           = 1'b1;
                state_next    = S_BR6;
            end
            S_BR6: begin
                BusDataSelect = BUS_ZLO;
                e_PC          = con_ff;
                state_next    = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = auto_run ? S_T0 : S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_branch_fetch_seq.sv
// tb/tb_branch_fetch_seq.sv - directed self-checking bench for branch_fetch_seq

module tb_branch_fetch_seq;

    logic       clock = 1'b0;
    logic       clear, start, auto_run, con_ff;
    logic [4:0] ir_opcode;

    logic       a_incPC, a_e_PC, a_e_IR, a_e_Y, a_e_Z, a_e_MAR, a_e_MDR, a_MDR_read;
    logic       a_ram_read, a_Gra, a_e_Rout, a_e_CON_FF, a_imm_sel;
    logic [4:0] a_bus;
    logic [3:0] a_alu;
    logic       a_busy, a_done, a_illegal, a_taken;
    logic [1:0] a_cnt;

    logic       b_incPC, b_e_PC, b_e_IR, b_e_Y, b_e_Z, b_e_MAR, b_e_MDR, b_MDR_read;
    logic       b_ram_read, b_Gra, b_e_Rout, b_e_CON_FF, b_imm_sel;
    logic [4:0] b_bus;
    logic [3:0] b_alu;
    logic       b_busy, b_done, b_illegal, b_taken;
    logic [15:0] b_cnt;

    logic [25:0] a_all;
    assign a_all = {a_incPC, a_e_PC, a_e_IR, a_e_Y, a_e_Z, a_e_MAR, a_e_MDR, a_MDR_read,
                    a_ram_read, a_Gra, a_e_Rout, a_e_CON_FF, a_imm_sel,
                    a_bus, a_alu, a_busy, a_done, a_illegal, a_taken};

    branch_fetch_seq #(.MEM_WAIT(1), .BR_OPCODE(5'b01001), .CNT_W(2)) u_dut (
        .clock(clock), .clear(clear), .start(start), .auto_run(auto_run),
        .ir_opcode(ir_opcode), .con_ff(con_ff),
        .incPC(a_incPC), .e_PC(a_e_PC), .e_IR(a_e_IR), .e_Y(a_e_Y), .e_Z(a_e_Z),
        .e_MAR(a_e_MAR), .e_MDR(a_e_MDR), .MDR_read(a_MDR_read), .ram_read(a_ram_read),
        .Gra(a_Gra), .e_Rout(a_e_Rout), .e_CON_FF(a_e_CON_FF), .imm_sel(a_imm_sel),
        .BusDataSelect(a_bus), .ALU_op(a_alu), .busy(a_busy), .done(a_done),
        .illegal(a_illegal), .taken(a_taken), .instr_count(a_cnt)
    );

    branch_fetch_seq #(.MEM_WAIT(4), .BR_OPCODE(5'b01001), .CNT_W(16)) u_dut_w4 (
        .clock(clock), .clear(clear), .start(start), .auto_run(auto_run),
        .ir_opcode(ir_opcode), .con_ff(con_ff),
        .incPC(b_incPC), .e_PC(b_e_PC), .e_IR(b_e_IR), .e_Y(b_e_Y), .e_Z(b_e_Z),
        .e_MAR(b_e_MAR), .e_MDR(b_e_MDR), .MDR_read(b_MDR_read), .ram_read(b_ram_read),
        .Gra(b_Gra), .e_Rout(b_e_Rout), .e_CON_FF(b_e_CON_FF), .imm_sel(b_imm_sel),
        .BusDataSelect(b_bus), .ALU_op(b_alu), .busy(b_busy), .done(b_done),
        .illegal(b_illegal), .taken(b_taken), .instr_count(b_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int w_cyc, w_done_cyc, w_done_n, w_rr_n, w_epc_n, w_epc_cyc, w_ill_cyc, w_br3_n;

    // Pulse start, then follow the selected DUT until it returns to IDLE.
    // Cycle i is the i-th rising edge after start was first driven high.
    task automatic watch(input bit sel, input int limit);
        w_cyc = -1; w_done_cyc = -1; w_done_n = 0; w_rr_n = 0;
        w_epc_n = 0; w_epc_cyc = -1; w_ill_cyc = -1; w_br3_n = 0;
        start = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (i == 1) start = 1'b0;
            if (sel ? b_done : a_done) begin
                w_done_n++;
                if (w_done_cyc < 0) w_done_cyc = i;
            end
            if (sel ? b_ram_read : a_ram_read) w_rr_n++;
            if (sel ? b_e_PC : a_e_PC) begin
                w_epc_n++;
                w_epc_cyc = i;
            end
            if ((sel ? b_illegal : a_illegal) && w_ill_cyc < 0) w_ill_cyc = i;
            if (sel ? (b_Gra | b_e_CON_FF) : (a_Gra | a_e_CON_FF)) w_br3_n++;
            if (!(sel ? b_busy : a_busy)) begin
                w_cyc = i;
                break;
            end
        end
        check("watch_returned_idle", 32'(w_cyc > 0), 32'd1);
    endtask

    int exp_cnt [5] = '{1, 2, 3, 0, 1};

    initial begin
        clear = 1'b0; start = 1'b0; auto_run = 1'b0; con_ff = 1'b0; ir_opcode = 5'd0;
        step(); step();
        check("reset_outputs", 32'(a_all), 32'd0);
        check("reset_count", 32'(a_cnt), 32'd0);
        clear = 1'b1;
        step();

        // Taken branch
        ir_opcode = 5'b01001; con_ff = 1'b1;
        watch(1'b0, 40);
        check("taken_done_cycle", 32'(w_done_cyc), 32'd12);
        check("taken_done_width", 32'(w_done_n), 32'd1);
        check("taken_epc_n", 32'(w_epc_n), 32'd1);
        check("taken_epc_cycle", 32'(w_epc_cyc), 32'd11);
        check("taken_flag", 32'(a_taken), 32'd1);
        check("taken_count", 32'(a_cnt), 32'd1);
        check("taken_no_illegal", 32'(w_ill_cyc), 32'hFFFF_FFFF);

        // Not taken
        con_ff = 1'b0;
        watch(1'b0, 40);
        check("nt_done_cycle", 32'(w_done_cyc), 32'd12);
        check("nt_epc_n", 32'(w_epc_n), 32'd0);
        check("nt_flag", 32'(a_taken), 32'd0);
        check("nt_count", 32'(a_cnt), 32'd2);

        // Illegal opcode
        ir_opcode = 5'b00011; con_ff = 1'b1;
        watch(1'b0, 40);
        check("ill_cycle", 32'(w_ill_cyc), 32'd8);
        check("ill_idle_cycle", 32'(w_cyc), 32'd9);
        check("ill_no_done", 32'(w_done_n), 32'd0);
        check("ill_no_br3", 32'(w_br3_n), 32'd0);
        check("ill_count", 32'(a_cnt), 32'd2);

        // Reset in the middle of BR5
        ir_opcode = 5'b01001; con_ff = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 2; i <= 10; i++) step();
        check("rst_in_br5_bus", 32'(a_bus), 32'b01100);
        clear = 1'b0;
        step();
        check("rst_outputs", 32'(a_all), 32'd0);
        check("rst_count", 32'(a_cnt), 32'd0);
        step();
        check("rst_no_done_1", 32'(a_done), 32'd0);
        step();
        check("rst_no_done_2", 32'(a_done), 32'd0);
        clear = 1'b1;
        step();
        check("rst_stays_idle", 32'(a_busy), 32'd0);
        check("rst_w4_count", 32'(b_cnt), 32'd0);

        // Memory wait states on the MEM_WAIT=4 instance
        watch(1'b1, 40);
        check("w4_ram_read_n", 32'(w_rr_n), 32'd5);
        check("w4_done_cycle", 32'(w_done_cyc), 32'd15);
        check("w4_count", 32'(b_cnt), 32'd1);
        for (int i = 0; i < 4; i++) step();

        // Free run with counter wrap; start pulse while busy must be ignored
        clear = 1'b0;
        step();
        clear = 1'b1;
        auto_run = 1'b1;
        begin
            int  nd = 0;
            bit  pend = 1'b0;
            int  last_done = -1;
            start = 1'b1;
            for (int i = 1; i <= 100 && !(nd == 5 && !pend); i++) begin
                step();
                if (i == 1) start = 1'b0;
                if (i == 20) start = 1'b1;
                if (i == 21) start = 1'b0;
                if (pend) begin
                    pend = 1'b0;
                    if (nd < 5)
                        check("frun_t0_follows",
                              32'({a_bus, a_e_MAR, a_incPC}), 32'({5'b10100, 1'b1, 1'b1}));
                    else
                        check("frun_final_idle", 32'(a_busy), 32'd0);
                    check("frun_count", 32'(a_cnt), 32'(exp_cnt[nd-1]));
                    if (nd == 4) auto_run = 1'b0;
                end
                if (a_done) begin
                    if (last_done >= 0) check("frun_period", 32'(i - last_done), 32'd12);
                    last_done = i;
                    nd++;
                    pend = 1'b1;
                end
            end
            check("frun_done_total", 32'(nd), 32'd5);
        end
        step(); step(); step();
        check("frun_still_idle", 32'(a_busy), 32'd0);
        check("frun_count_hold", 32'(a_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
